conv_window_gen: RTL and testbench

//  Upstream feeder for the 3x3 conv unit: turns a raster pixel stream into 3x3 sliding windows.
//  Two internal row buffers hold the previous two image rows.

---
 rtl/conv_window_gen_pkg.sv | 17 +
 rtl/conv_window_gen_line_buffer.sv | 37 +++
 rtl/conv_window_gen.sv | 150 +++++++++++++++
 tb/tb_conv_window_gen.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg
//   Constants shared by the 3x3 window generator and its row buffers.
//   KERNEL_K : kernel edge length (3x3 window)
//   WIN_TAPS : number of window taps, row-major, tap 0 = oldest top-left
//   EMIT_MIN : first row/column index at which a full neighbourhood exists
//   tap()    : maps (window row, window col) to the row-major tap index
package conv_window_gen_pkg;

  localparam int KERNEL_K = 3;
  localparam int WIN_TAPS = KERNEL_K * KERNEL_K;
  localparam int EMIT_MIN = KERNEL_K - 1;

  function automatic int tap(input int row, input int col);
    return row * KERNEL_K + col;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer
//   One image row of storage. Synchronous write, combinational read.
//   A read and a write to the same address in the same cycle return the
//   old contents, which is what lets the row data cascade between the two
//   buffers in a single cycle.
// Ports
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_addr  : shared read/write address (column)
//   i_wdata : write data
//   o_rdata : read data at i_addr (value before this cycle's write)
module line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  // Contents are intentionally not reset: stale data is overwritten before
  // any window that would use it can be emitted.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Turns a raster pixel stream into 3x3 sliding windows (valid padding,
//   stride 1). Two row buffers hold the previous two rows; a 3x3 register
//   window shifts left on every accepted pixel and loads the new right
//   column {rowbuf1[col], rowbuf0[col], pixel}.
// Ports
//   clk, rst            : clock (rising edge), async active-high reset
//   pix_valid/pix_ready : input pixel handshake
//   pix_data            : raster-order pixel, row 0 col 0 first
//   win0..win8          : window, row-major; win0 = (r-2,c-2), win8 = (r,c)
//   win_valid/win_ready : output window handshake
//   frame_done          : 1-cycle pulse after the last pixel of a frame
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. The window is held stable while win_valid & !win_ready, and
//   pix_ready = !win_valid | win_ready, so no pixel is taken while a window
//   is stuck downstream.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_EMIT = COL_W'(EMIT_MIN);
  localparam logic [ROW_W-1:0] ROW_EMIT = ROW_W'(EMIT_MIN);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_win [WIN_TAPS];
  logic              r_win_valid;
  logic              r_frame_done;

  logic              w_acc;
  logic              w_emit;
  logic              w_col_last;
  logic              w_row_last;
  logic [DATA_W-1:0] w_rb0_rd;
  logic [DATA_W-1:0] w_rb1_rd;

  assign pix_ready  = !r_win_valid || win_ready;
  assign w_acc      = pix_valid && pix_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  // Columns 0..1 of each row and rows 0..1 of each frame only prime the
  // window; this is also what keeps stale row-buffer data from escaping.
  assign w_emit     = (r_row >= ROW_EMIT) && (r_col >= COL_EMIT);

  // rowbuf0 holds row r-1, rowbuf1 holds row r-2. On accept, rowbuf0's old
  // value at this column cascades into rowbuf1 in the same cycle.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_rowbuf0 (
    .i_clk   (clk),
    .i_we    (w_acc),
    .i_addr  (r_col),
    .i_wdata (pix_data),
    .o_rdata (w_rb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_rowbuf1 (
    .i_clk   (clk),
    .i_we    (w_acc),
    .i_addr  (r_col),
    .i_wdata (w_rb0_rd),
    .o_rdata (w_rb1_rd)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // 3x3 register window: shift left, load the new right column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_TAPS; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_acc) begin
      for (int r = 0; r < KERNEL_K; r++) begin
        for (int c = 0; c < KERNEL_K - 1; c++) begin
          r_win[tap(r, c)] <= r_win[tap(r, c + 1)];
        end
      end
      r_win[tap(0, KERNEL_K - 1)] <= w_rb1_rd;
      r_win[tap(1, KERNEL_K - 1)] <= w_rb0_rd;
      r_win[tap(2, KERNEL_K - 1)] <= pix_data;
    end
  end

  // An accept can only happen when the current window is consumed or
  // absent, so on accept win_valid simply follows w_emit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_acc) begin
        r_win_valid <= w_emit;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
      r_frame_done <= w_acc && w_col_last && w_row_last;
    end
  end

  assign win0       = r_win[0];
  assign win1       = r_win[1];
  assign win2       = r_win[2];
  assign win3       = r_win[3];
  assign win4       = r_win[4];
  assign win5       = r_win[5];
  assign win6       = r_win[6];
  assign win7       = r_win[7];
  assign win8       = r_win[8];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: instance a is a 4x4 image, instance b is 5x3.
// The model records every accepted pixel into an image array at its raster
// position and cuts the expected 3x3 neighbourhood from that array.
module tb_conv_window_gen;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int AH = 4;
  localparam int BW = 5;
  localparam int BH = 3;

  typedef logic [9*DW-1:0] win_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT a (4x4) ----------------
  logic          a_pix_valid, a_pix_ready, a_win_valid, a_win_ready, a_frame_done;
  logic [DW-1:0] a_pix_data;
  logic [DW-1:0] a_win [0:8];

  conv_window_gen #(.DATA_W(DW), .IMG_W(AW), .IMG_H(AH)) dut_a (
    .clk(clk), .rst(rst), .pix_valid(a_pix_valid), .pix_ready(a_pix_ready),
    .pix_data(a_pix_data),
    .win0(a_win[0]), .win1(a_win[1]), .win2(a_win[2]), .win3(a_win[3]),
    .win4(a_win[4]), .win5(a_win[5]), .win6(a_win[6]), .win7(a_win[7]),
    .win8(a_win[8]),
    .win_valid(a_win_valid), .win_ready(a_win_ready), .frame_done(a_frame_done)
  );

  // ---------------- DUT b (5x3) ----------------
  logic          b_pix_valid, b_pix_ready, b_win_valid, b_win_ready, b_frame_done;
  logic [DW-1:0] b_pix_data;
  logic [DW-1:0] b_win [0:8];

  conv_window_gen #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH)) dut_b (
    .clk(clk), .rst(rst), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
    .pix_data(b_pix_data),
    .win0(b_win[0]), .win1(b_win[1]), .win2(b_win[2]), .win3(b_win[3]),
    .win4(b_win[4]), .win5(b_win[5]), .win6(b_win[6]), .win7(b_win[7]),
    .win8(b_win[8]),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .frame_done(b_frame_done)
  );

  // ---------------- check helpers ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check_w(input string name, input win_t act, input win_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic win_t pack9(input logic [DW-1:0] v [0:8]);
    win_t p;
    for (int k = 0; k < 9; k++) p[DW*(8-k) +: DW] = v[k];
    return p;
  endfunction

  function automatic win_t w9(input int v0, input int v1, input int v2,
                              input int v3, input int v4, input int v5,
                              input int v6, input int v7, input int v8);
    return {v0[DW-1:0], v1[DW-1:0], v2[DW-1:0], v3[DW-1:0], v4[DW-1:0],
            v5[DW-1:0], v6[DW-1:0], v7[DW-1:0], v8[DW-1:0]};
  endfunction

  function automatic int sum9(input win_t p);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'(p[DW*k +: DW]);
    return s;
  endfunction

  // Expected window for the pixel at (r,c): rows r-2..r, cols c-2..c.
  function automatic win_t model_win(input logic [DW-1:0] img [0:31],
                                     input int w, input int r, input int c);
    win_t p;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        p[DW*(8-(dr*3+dc)) +: DW] = img[(r-2+dr)*w + (c-2+dc)];
    return p;
  endfunction

  // ---------------- scoreboard a ----------------
  logic [DW-1:0] a_img [0:31];
  win_t          a_exp_q[$];
  win_t          a_seen[$];
  int            a_pos, a_fd_seen;
  logic          a_exp_valid, a_exp_fd, a_hold;
  win_t          a_hold_win;

  initial begin : a_compare
    int r, c;
    logic m_ready;
    win_t got;
    a_pos = 0; a_fd_seen = 0; a_exp_valid = 1'b0; a_exp_fd = 1'b0; a_hold = 1'b0;
    forever begin
      @(negedge clk); #2;
      got = pack9(a_win);
      if (rst) begin
        check_i("a_rst_valid", int'(a_win_valid), 0);
        check_i("a_rst_done", int'(a_frame_done), 0);
        check_w("a_rst_win", got, '0);
        a_pos = 0; a_exp_valid = 1'b0; a_exp_fd = 1'b0; a_hold = 1'b0;
        a_exp_q.delete();
      end else begin
        m_ready = !a_exp_valid || a_win_ready;
        check_i("a_win_valid", int'(a_win_valid), int'(a_exp_valid));
        check_i("a_frame_done", int'(a_frame_done), int'(a_exp_fd));
        check_i("a_pix_ready", int'(a_pix_ready), int'(m_ready));
        if (a_frame_done) a_fd_seen++;
        if (a_hold) check_w("a_hold_win", got, a_hold_win);
        if (a_win_valid && a_win_ready) begin
          if (a_exp_q.size() == 0) check_i("a_unexpected_win", 1, 0);
          else check_w("a_win", got, a_exp_q.pop_front());
          a_seen.push_back(got);
        end
        a_hold = a_win_valid && !a_win_ready;
        a_hold_win = got;
        a_exp_fd = 1'b0;
        if (a_pix_valid && m_ready) begin
          r = a_pos / AW;
          c = a_pos % AW;
          a_img[a_pos] = a_pix_data;
          a_exp_valid = (r >= 2 && c >= 2);
          if (a_exp_valid) a_exp_q.push_back(model_win(a_img, AW, r, c));
          if (a_pos == AW*AH-1) begin a_pos = 0; a_exp_fd = 1'b1; end
          else a_pos++;
        end else if (a_win_ready) begin
          a_exp_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard b ----------------
  logic [DW-1:0] b_img [0:31];
  win_t          b_exp_q[$];
  win_t          b_seen[$];
  int            b_pos, b_fd_seen;
  logic          b_exp_valid, b_exp_fd, b_hold;
  win_t          b_hold_win;

  initial begin : b_compare
    int r, c;
    logic m_ready;
    win_t got;
    b_pos = 0; b_fd_seen = 0; b_exp_valid = 1'b0; b_exp_fd = 1'b0; b_hold = 1'b0;
    forever begin
      @(negedge clk); #2;
      got = pack9(b_win);
      if (rst) begin
        b_pos = 0; b_exp_valid = 1'b0; b_exp_fd = 1'b0; b_hold = 1'b0;
        b_exp_q.delete();
      end else begin
        m_ready = !b_exp_valid || b_win_ready;
        check_i("b_win_valid", int'(b_win_valid), int'(b_exp_valid));
        check_i("b_frame_done", int'(b_frame_done), int'(b_exp_fd));
        check_i("b_pix_ready", int'(b_pix_ready), int'(m_ready));
        if (b_frame_done) b_fd_seen++;
        if (b_hold) check_w("b_hold_win", got, b_hold_win);
        if (b_win_valid && b_win_ready) begin
          if (b_exp_q.size() == 0) check_i("b_unexpected_win", 1, 0);
          else check_w("b_win", got, b_exp_q.pop_front());
          b_seen.push_back(got);
        end
        b_hold = b_win_valid && !b_win_ready;
        b_hold_win = got;
        b_exp_fd = 1'b0;
        if (b_pix_valid && m_ready) begin
          r = b_pos / BW;
          c = b_pos % BW;
          b_img[b_pos] = b_pix_data;
          b_exp_valid = (r >= 2 && c >= 2);
          if (b_exp_valid) b_exp_q.push_back(model_win(b_img, BW, r, c));
          if (b_pos == BW*BH-1) begin b_pos = 0; b_exp_fd = 1'b1; end
          else b_pos++;
        end else if (b_win_ready) begin
          b_exp_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Sends pixels base..base+count-1; optionally holds win_ready low for 3
  // cycles as soon as the first window shows up.
  task automatic a_send(input int base, input int count, input int valid_pct,
                        input bit stall_first);
    int idx = 0, stall = 0, guard = 0;
    bit stalled = 1'b0;
    while (idx < count && guard < 500) begin
      @(negedge clk);
      if (stall_first && !stalled && a_win_valid) begin stall = 3; stalled = 1'b1; end
      a_win_ready = (stall == 0);
      if (stall > 0) stall--;
      a_pix_valid = (int'($urandom_range(99)) < valid_pct);
      a_pix_data  = DW'(base + idx);
      #1;
      if (a_pix_valid && a_pix_ready) idx++;
      guard++;
    end
    if (idx < count) check_i("a_send_timeout", idx, count);
  endtask

  task automatic a_drain();
    repeat (4) begin
      @(negedge clk);
      a_pix_valid = 1'b0;
      a_win_ready = 1'b1;
    end
  endtask

  task automatic b_send(input int count);
    int idx = 0, guard = 0;
    while (idx < count && guard < 500) begin
      @(negedge clk);
      b_win_ready = (int'($urandom_range(99)) < 70);
      b_pix_valid = (int'($urandom_range(99)) < 50);
      b_pix_data  = DW'(idx);
      #1;
      if (b_pix_valid && b_pix_ready) idx++;
      guard++;
    end
    if (idx < count) check_i("b_send_timeout", idx, count);
    repeat (4) begin
      @(negedge clk);
      b_pix_valid = 1'b0;
      b_win_ready = 1'b1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  win_t t1_log[$];

  initial begin
    rst = 1'b1;
    a_pix_valid = 1'b0; a_pix_data = '0; a_win_ready = 1'b1;
    b_pix_valid = 1'b0; b_pix_data = '0; b_win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;
    check_i("reset_pix_ready", int'(a_pix_ready), 1);

    // Test 1: plain 0..15 frame, continuous valid, win_ready=1
    a_seen.delete(); a_fd_seen = 0;
    a_send(0, 16, 100, 1'b0);
    a_drain();
    check_i("t1_count", a_seen.size(), 4);
    check_i("t1_frame_done", a_fd_seen, 1);
    if (a_seen.size() == 4) begin
      check_w("t1_first", a_seen[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      check_w("t1_last", a_seen[3], w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
      // Test 6: all-ones kernel sums
      check_i("t6_sum0", sum9(a_seen[0]), 45);
      check_i("t6_sum1", sum9(a_seen[1]), 54);
      check_i("t6_sum2", sum9(a_seen[2]), 81);
      check_i("t6_sum3", sum9(a_seen[3]), 90);
    end
    t1_log = a_seen;

    // Test 2: downstream stalls 3 cycles at the first window
    a_seen.delete(); a_fd_seen = 0;
    a_send(0, 16, 100, 1'b1);
    a_drain();
    check_i("t2_count", a_seen.size(), 4);
    check_i("t2_frame_done", a_fd_seen, 1);
    for (int i = 0; i < 4 && i < a_seen.size(); i++) check_w("t2_seq", a_seen[i], t1_log[i]);

    // Test 3: two frames back to back
    a_seen.delete(); a_fd_seen = 0;
    a_send(0, 16, 100, 1'b0);
    a_send(100, 16, 100, 1'b0);
    a_drain();
    check_i("t3_count", a_seen.size(), 8);
    check_i("t3_frame_done", a_fd_seen, 2);
    if (a_seen.size() == 8) begin
      check_w("t3_f2_first", a_seen[4], w9(100, 101, 102, 104, 105, 106, 108, 109, 110));
      check_w("t3_f2_last", a_seen[7], w9(105, 106, 107, 109, 110, 111, 113, 114, 115));
    end

    // Test 4: async reset in the middle of row 2 with a window pending
    a_send(0, 11, 100, 1'b0);
    @(posedge clk); #2;
    check_i("t4_pending", int'(a_win_valid), 1);
    #1;
    rst = 1'b1;
    a_pix_valid = 1'b0;
    #1;
    check_i("t4_async_valid", int'(a_win_valid), 0);
    check_w("t4_async_win", pack9(a_win), '0);
    check_i("t4_async_ready", int'(a_pix_ready), 1);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    a_seen.delete(); a_fd_seen = 0;
    a_send(0, 16, 100, 1'b0);
    a_drain();
    check_i("t4_count", a_seen.size(), 4);
    check_i("t4_frame_done", a_fd_seen, 1);
    for (int i = 0; i < 4 && i < a_seen.size(); i++) check_w("t4_seq", a_seen[i], t1_log[i]);

    // Test 5: 5x3 image, random valid gaps and random downstream stalls
    b_seen.delete(); b_fd_seen = 0;
    b_send(15);
    check_i("t5_count", b_seen.size(), 3);
    check_i("t5_frame_done", b_fd_seen, 1);
    if (b_seen.size() == 3) begin
      check_w("t5_first", b_seen[0], w9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      check_w("t5_last", b_seen[2], w9(2, 3, 4, 7, 8, 9, 12, 13, 14));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
